reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Next-generation general-purpose register file for the decode stage.
- Generalised to a parametrised number of read and write ports.
- Adds synchronous reset, same-cycle write-to-read bypass and an integrated busy-bit scoreboard for RAW hazard detection.
- Sits between the decode logic (read/issue side) and writeback (write side); feeds the hazard unit a stall request.

Parameters:
- N, `XLEN, data width of each register.
- NREAD, 2, number of read ports (1..4).
- NWRITE, 1, number of write ports (1..2).
- NREGS, `GPRS_COUNT, number of architectural registers; register 0 is hardwired zero.
- AW, `GPR_ENCODE_BITS, register address width; NREGS <= 2**AW.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- rs_valid  in  NREAD  per read port: operand is actually used.
- rs_addr  in  NREAD*AW  read addresses; port i at bits [i*AW +: AW].
- rs_data  out  NREAD*N  read data; port i at bits [i*N +: N].
- rs_busy  out  NREAD  per read port: operand still pending after bypass.
- stall  out  1  OR over i of (rs_valid[i] & rs_busy[i]).
- iss_valid  in  1  an instruction with a destination issues this cycle.
- iss_rd  in  AW  destination of the issuing instruction.
- we  in  NWRITE  per write port enable.
- wa  in  NWRITE*AW  write addresses.
- wd  in  NWRITE*N  write data.

Behaviour:
- Reset: when rst_n=0 at posedge, all registers become 0 and all busy bits become 0; writes and issues in that cycle are ignored. rs_data is combinational, so it reads 0 from the cycle after reset.
- Reads are combinational, zero latency.
  - rs_data[i] = 0 when rs_addr[i]==0.
  - Else, if any write port j has we[j] && wa[j]==rs_addr[i], return wd[j] (bypass); the highest-index such j wins.
  - Else return the stored value.
- Writes commit at posedge with one-cycle latency to storage (bypass covers the same cycle).
  - A write to address 0 is discarded.
  - Two write ports to the same address in one cycle: the highest-index port's data is stored.
  - Address >= NREGS: write discarded; read returns 0 and busy 0.
- Scoreboard: one busy bit per register; bit 0 is constant 0.
  - Set at posedge when iss_valid && iss_rd!=0.
  - Cleared at posedge when any we[j] && wa[j] targets the register.
  - Set and clear on the same register in the same cycle: the set wins, because a new producer supersedes the retiring one. Data is still written.
- rs_busy[i] = busy[rs_addr[i]] && no write port hits rs_addr[i] this cycle. A same-cycle writeback clears the hazard combinationally.
  - iss_valid in the current cycle does not affect rs_busy in the same cycle. The issuing instruction's own sources see the prior state.
- stall is purely combinational from the above and carries no state.
- Write without a prior issue (busy already 0) is legal; busy stays 0.
- Reset asserted mid-operation overrides all pending sets and clears; there is no partially retained state.

Decomposition:
- Reuse `XLEN, `GPR_ENCODE_BITS and `GPRS_COUNT from constants.sv.
- Add `RF_MAX_READ_PORTS (4) and `RF_MAX_WRITE_PORTS (2) there, for parameter range checks.
- One sub-module, rf_scoreboard: NREGS busy bits with set/clear priority logic and the per-port rs_busy lookup.
  - It is parametrised on NREGS, AW, NREAD and NWRITE, and takes the write-port hit vector as an input.
- Storage, bypass muxing and stall generation stay in reg_file_sb.
- Parameter legality is checked with elaboration-time assertions.

Test Plan:
- Reset: load x5=0xDEADBEEF, set busy via iss_rd=5, then pulse rst_n=0 for one cycle -> rs_data for x5 is 0, rs_busy 0, stall 0.
- x0: we=1, wa=0, wd=0xFFFFFFFF; rs_addr=0 in the same cycle and the next -> rs_data=0 both cycles; iss_rd=0 never sets busy.
- Bypass: we=1, wa=7, wd=0x1234; rs_addr[1]=7 in the same cycle -> rs_data[1]=0x1234 immediately. Next cycle with we=0 -> 0x1234 from storage.
- Scoreboard RAW:
  - iss_valid, iss_rd=3 at cycle t.
  - Cycle t+1, rs_valid[0]=1, rs_addr[0]=3 -> rs_busy[0]=1, stall=1.
  - Writeback to x3 at t+2 -> same cycle rs_busy=0, stall=0, data bypassed.
  - Same address read with rs_valid=0 -> stall=0.
- Set/clear collision: x9 busy; in one cycle we=1, wa=9, wd=0x55 and iss_valid, iss_rd=9 -> next cycle x9 reads 0x55 and busy=1.
- Dual write (NWRITE=2): both ports target x4 with 0xA and 0xB -> bypass and stored value are 0xB; busy for x4 is cleared.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the decode-stage register file with scoreboard.
`include "constants.sv"

package reg_file_sb_pkg;

  // Upper limits on port counts accepted by reg_file_sb.
  localparam int RF_MAX_RD = `RF_MAX_READ_PORTS;
  localparam int RF_MAX_WR = `RF_MAX_WRITE_PORTS;

endpackage

// File: rtl/constants.sv
// Machine-wide constants shared across the core.
`ifndef CONSTANTS_SV
`define CONSTANTS_SV

`define XLEN               32
`define GPR_ENCODE_BITS    5
`define GPRS_COUNT         32
`define RF_MAX_READ_PORTS  4
`define RF_MAX_WRITE_PORTS 2

`endif

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per architectural register,
// with issue-over-writeback priority and per-read-port hazard lookup.
`include "constants.sv"

module rf_scoreboard #(
  parameter int NREGS  = `GPRS_COUNT,
  parameter int AW     = `GPR_ENCODE_BITS,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               iss_valid,
  input  logic [AW-1:0]                      iss_rd,
  input  logic [NWRITE-1:0]                  we,
  input  logic [NWRITE*AW-1:0]               wa,
  input  logic [NREAD*AW-1:0]                rs_addr,
  input  logic [NREAD-1:0][NWRITE-1:0]       rd_wr_hit,
  output logic [NREAD-1:0]                   rs_busy
);

  // Register 0 never has a producer, so it has no storage bit.
  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:1] busy_d;

  // Next busy state: writeback clears, a new issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && (wa[j*AW +: AW] == AW'(r))) begin
          busy_d[r] = 1'b0;
        end
      end
      if (iss_valid && (iss_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  // Busy bit register; reset drops every pending producer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Per-port hazard: stored busy bit, masked when a writeback lands this cycle.
  always_comb begin
    rs_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (rs_addr[i*AW +: AW] == AW'(r)) begin
          rs_busy[i] = busy_q[r];
        end
      end
      if (|rd_wr_hit[i]) begin
        rs_busy[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Decode-stage register file: multi-port storage with x0 hardwired to zero,
// same-cycle write-to-read bypass, and a RAW scoreboard driving stall.
`include "constants.sv"

module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int N      = `XLEN,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  parameter int NREGS  = `GPRS_COUNT,
  parameter int AW     = `GPR_ENCODE_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD-1:0]       rs_valid,
  input  logic [NREAD*AW-1:0]    rs_addr,
  output logic [NREAD*N-1:0]     rs_data,
  output logic [NREAD-1:0]       rs_busy,
  output logic                   stall,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   wa,
  input  logic [NWRITE*N-1:0]    wd
);

  if ((NREAD < 1) || (NREAD > RF_MAX_RD)) begin : g_bad_nread
    $error("reg_file_sb: NREAD out of range");
  end
  if ((NWRITE < 1) || (NWRITE > RF_MAX_WR)) begin : g_bad_nwrite
    $error("reg_file_sb: NWRITE out of range");
  end
  if ((NREGS < 2) || (NREGS > (1 << AW))) begin : g_bad_nregs
    $error("reg_file_sb: NREGS does not fit in AW address bits");
  end

  // x0 is not stored; reads of it fall through to zero.
  logic [NREGS-1:1][N-1:0]       regs_q;
  logic [NREGS-1:1][N-1:0]       regs_d;
  logic [NREAD-1:0]              addr_ok;
  logic [NREAD-1:0][NWRITE-1:0]  rd_wr_hit;
  logic [NREAD-1:0][N-1:0]       rd_data;
  logic [NREAD-1:0]              sb_busy;

  // Which write ports hit each read port; only real, nonzero registers count.
  always_comb begin
    addr_ok   = '0;
    rd_wr_hit = '0;
    for (int i = 0; i < NREAD; i++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (rs_addr[i*AW +: AW] == AW'(r)) begin
          addr_ok[i] = 1'b1;
        end
      end
      for (int j = 0; j < NWRITE; j++) begin
        rd_wr_hit[i][j] = addr_ok[i] && we[j] &&
                          (wa[j*AW +: AW] == rs_addr[i*AW +: AW]);
      end
    end
  end

  // Read mux: stored value, overridden by the highest-index bypassing writer.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREAD; i++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (rs_addr[i*AW +: AW] == AW'(r)) begin
          rd_data[i] = regs_q[r];
        end
      end
      for (int j = 0; j < NWRITE; j++) begin
        if (rd_wr_hit[i][j]) begin
          rd_data[i] = wd[j*N +: N];
        end
      end
    end
  end

  // Write decode: later ports overwrite earlier ones on an address collision.
  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < NREGS; r++) begin
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && (wa[j*AW +: AW] == AW'(r))) begin
          regs_d[r] = wd[j*N +: N];
        end
      end
    end
  end

  // Architectural storage; reset clears every register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .we        (we),
    .wa        (wa),
    .rs_addr   (rs_addr),
    .rd_wr_hit (rd_wr_hit),
    .rs_busy   (sb_busy)
  );

  assign rs_data = rd_data;
  assign rs_busy = sb_busy;
  assign stall   = |(rs_valid & sb_busy);

endmodule
